// File: rtl/a2d_pkg.sv
// Shared types and constants for the A2D conversion handshake and its SPI frame engine.
// The command word carries the ADC channel in bits 13:11 with every other bit zero.
package a2d_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    GAP,
    READ,
    DONE
  } state_t;

  localparam int FRAME_BITS = 16;
  localparam int RES_BITS   = 12;
  localparam int CH_BITS    = 3;
  localparam int CH_LSB     = 11;
  localparam int CH_MSB     = CH_LSB + CH_BITS - 1;

  function automatic logic [FRAME_BITS-1:0] cmd_word(input logic [CH_BITS-1:0] ch);
    logic [FRAME_BITS-1:0] w;
    w = '0;
    w[CH_MSB:CH_LSB] = ch;
    return w;
  endfunction

endpackage

// File: rtl/a2d_intf_if.sv
// Request/result handshake toward the motion controller plus the SPI pins toward the ADC.
// slave is the converter side; master is the environment (controller and ADC).
interface a2d_intf_if;
  import a2d_pkg::*;

  logic                  start_conv;
  logic [CH_BITS-1:0]    chnnl;
  logic                  cnv_cmplt;
  logic [RES_BITS-1:0]   A2D_res;
  logic                  SS_n;
  logic                  SCLK;
  logic                  MOSI;
  logic                  MISO;

  modport slave (
    input  start_conv,
    input  chnnl,
    input  MISO,
    output cnv_cmplt,
    output A2D_res,
    output SS_n,
    output SCLK,
    output MOSI
  );

  modport master (
    output start_conv,
    output chnnl,
    output MISO,
    input  cnv_cmplt,
    input  A2D_res,
    input  SS_n,
    input  SCLK,
    input  MOSI
  );

endinterface

// File: rtl/a2d_intf_spi_frame16.sv
// One 16-bit SPI frame: SS_n low for 17 SCLK periods, half-period porches at both ends,
// SCLK idle high, MISO held on SCLK rise and shifted in on the following fall.
module spi_frame16
  import a2d_pkg::*;
#(
  parameter int SCLK_DIV = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wrt,
  input  logic [FRAME_BITS-1:0] cmd,
  output logic                  done,
  output logic [FRAME_BITS-1:0] rx,
  output logic                  SS_n,
  output logic                  SCLK,
  output logic                  MOSI,
  input  logic                  MISO
);

  localparam int FRAME_CLKS = (FRAME_BITS + 1) * SCLK_DIV;
  localparam int CW         = $clog2(FRAME_CLKS + 1);
  localparam int PH         = $clog2(SCLK_DIV) - 1;

  localparam logic [CW-1:0] PORCH_END = CW'(SCLK_DIV / 2);
  localparam logic [CW-1:0] BP_START  = CW'(FRAME_CLKS - SCLK_DIV / 2);
  localparam logic [CW-1:0] LAST_CNT  = CW'(FRAME_CLKS - 1);

  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_nxt;
  logic                  sclk_nxt;
  logic                  sclk_rise;
  logic                  shift_en;
  logic                  miso_hold;
  logic [FRAME_BITS-1:0] shreg;

  // SCLK is low in the upper half of each period once past the front porch; since the
  // porch is exactly half a period, bit PH of the frame count marks the low half directly.
  // The first fall carries no received bit; the last bit shifts in at the back porch start.
  always_comb begin
    cnt_nxt   = cnt + CW'(1);
    sclk_nxt  = ~((cnt_nxt >= PORCH_END) && (cnt_nxt < BP_START) && cnt_nxt[PH]);
    sclk_rise = ~SS_n && ~SCLK && sclk_nxt;
    shift_en  = ~SS_n && ((SCLK && ~sclk_nxt && (cnt_nxt != PORCH_END)) ||
                          (cnt_nxt == BP_START));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      SS_n      <= 1'b1;
      SCLK      <= 1'b1;
      done      <= 1'b0;
      miso_hold <= 1'b0;
      shreg     <= '0;
    end else begin
      done <= 1'b0;
      if (wrt && SS_n) begin
        cnt   <= '0;
        SS_n  <= 1'b0;
        SCLK  <= 1'b1;
        shreg <= cmd;
      end else if (!SS_n) begin
        if (cnt == LAST_CNT) begin
          SS_n <= 1'b1;
          done <= 1'b1;
        end else begin
          cnt  <= cnt_nxt;
          SCLK <= sclk_nxt;
          if (sclk_rise) begin
            miso_hold <= MISO;
          end
          if (shift_en) begin
            shreg <= {shreg[FRAME_BITS-2:0], miso_hold};
          end
        end
      end
    end
  end

  assign MOSI = shreg[FRAME_BITS-1];
  assign rx   = shreg;

endmodule

// File: rtl/a2d_intf.sv
// A2D conversion responder: a select frame, an SS_n-high gap, then a read frame whose
// low 12 received bits become A2D_res; cnv_cmplt then stays high until the next request.
module a2d_intf
  import a2d_pkg::*;
#(
  parameter int SCLK_DIV = 32,
  parameter int GAP_CLKS = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  a2d_intf_if.slave  bus
);

  localparam int GW = (GAP_CLKS > 2) ? $clog2(GAP_CLKS) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CLKS - 2);

  state_t                         state;
  logic [CH_BITS-1:0]             chnnl_q;
  logic [GW-1:0]                  gap_cnt;
  logic                           cmplt_q;
  logic [RES_BITS-1:0]            res_q;
  logic                           accept;
  logic                           gap_term;
  logic                           wrt;
  logic                           done;
  logic [FRAME_BITS-1:0]          frame_cmd;
  logic [FRAME_BITS-1:0]          rx;
  logic [FRAME_BITS-RES_BITS-1:0] rx_unused;

  // The frame is started combinationally so SS_n falls on the edge after the request;
  // on acceptance chnnl_q is not yet loaded, so the command comes straight from chnnl.
  always_comb begin
    accept    = bus.start_conv && ((state == IDLE) || (state == DONE));
    gap_term  = (state == GAP) && (gap_cnt == GAP_LAST);
    wrt       = accept || gap_term;
    frame_cmd = accept ? cmd_word(bus.chnnl) : cmd_word(chnnl_q);
  end

  assign rx_unused = rx[FRAME_BITS-1:RES_BITS];

  spi_frame16 #(
    .SCLK_DIV (SCLK_DIV)
  ) u_frame (
    .clk   (clk),
    .rst_n (rst_n),
    .wrt   (wrt),
    .cmd   (frame_cmd),
    .done  (done),
    .rx    (rx),
    .SS_n  (bus.SS_n),
    .SCLK  (bus.SCLK),
    .MOSI  (bus.MOSI),
    .MISO  (bus.MISO)
  );

  // The done cycle already has SS_n high, so the gap counter stops two short of GAP_CLKS.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      chnnl_q <= '0;
      gap_cnt <= '0;
      cmplt_q <= 1'b0;
      res_q   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start_conv) begin
            chnnl_q <= bus.chnnl;
            cmplt_q <= 1'b0;
            state   <= CMD;
          end
        end
        CMD: begin
          if (done) begin
            gap_cnt <= '0;
            state   <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= READ;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        READ: begin
          if (done) begin
            res_q   <= rx[RES_BITS-1:0];
            cmplt_q <= 1'b1;
            state   <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cnv_cmplt = cmplt_q;
  assign bus.A2D_res   = res_q;

endmodule

// File: tb/tb_a2d_intf.sv
// Bench for a2d_intf: a clock-sampled ADC128S-style model answers each frame with the
// data of the channel addressed in the previous frame, and frame timing is measured.
module tb_a2d_intf;

  localparam int SCLK_DIV  = 32;
  localparam int GAP_CLKS  = 32;
  localparam int FRAME_LOW = 17 * SCLK_DIV;
  localparam int LATENCY   = 2 * FRAME_LOW + GAP_CLKS + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  a2d_intf_if bus ();

  a2d_intf #(
    .SCLK_DIV (SCLK_DIV),
    .GAP_CLKS (GAP_CLKS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ADC model and frame monitor state
  logic [11:0] adc_data [8];
  int          last_ch = 0;
  logic        prev_ss = 1'b1;
  logic        prev_sclk = 1'b1;
  int          rises = 0;
  logic [15:0] mosi_word = '0;
  logic [15:0] miso_word = '0;
  int          fall_cyc = 0;
  int          rise_cyc = 0;
  bit          have_rise = 1'b0;
  int          idle_edges = 0;
  int          low_len_q [$];
  int          gap_q [$];
  int          rises_q [$];
  logic [15:0] mosi_q [$];

  // Sampled mid-cycle: latch MOSI on SCLK rise, present the next MISO bit after each fall.
  always @(negedge clk) begin
    if (prev_ss && !bus.SS_n) begin
      fall_cyc = cyc;
      if (have_rise) gap_q.push_back(cyc - rise_cyc);
      rises = 0;
      mosi_word = '0;
      miso_word = {4'($urandom), adc_data[last_ch]};
      bus.MISO = miso_word[15];
    end else if (!prev_ss && bus.SS_n) begin
      low_len_q.push_back(cyc - fall_cyc);
      mosi_q.push_back(mosi_word);
      rises_q.push_back(rises);
      if (rises == 16) last_ch = int'(mosi_word[13:11]);
      rise_cyc = cyc;
      have_rise = 1'b1;
    end else if (!bus.SS_n) begin
      if (!prev_sclk && bus.SCLK) begin
        mosi_word = {mosi_word[14:0], bus.MOSI};
        rises++;
      end else if (prev_sclk && !bus.SCLK && rises > 0 && rises < 16) begin
        bus.MISO = miso_word[15 - rises];
      end
    end else if (bus.SCLK !== prev_sclk) begin
      idle_edges++;
    end
    prev_ss = bus.SS_n;
    prev_sclk = bus.SCLK;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clearMon();
    low_len_q.delete();
    gap_q.delete();
    rises_q.delete();
    mosi_q.delete();
    have_rise = 1'b0;
  endtask

  task automatic applyStimulus(input logic [2:0] ch);
    bus.chnnl = ch;
    bus.start_conv = 1'b1;
    start_cyc = cyc;
    tick();
    bus.start_conv = 1'b0;
    bus.chnnl = 3'($urandom);
  endtask

  task automatic waitCmplt(input logic [11:0] prev_res, output int lat, output int changed);
    int n;
    lat = -1;
    changed = 0;
    n = 0;
    while (lat < 0 && n < 3000) begin
      if (bus.cnv_cmplt === 1'b1) begin
        lat = cyc - start_cyc;
      end else begin
        if (bus.A2D_res !== prev_res) changed = 1;
        tick();
        n++;
      end
    end
  endtask

  // Ends in the cycle cnv_cmplt is first seen high, so a following call is back-to-back.
  task automatic runConversion(input logic [2:0] ch, input logic [11:0] data,
                               input int busy_at, input string tag);
    logic [11:0] prev;
    logic [15:0] exp_cmd;
    int lat;
    int changed;
    prev = bus.A2D_res;
    adc_data[ch] = data;
    exp_cmd = {2'b00, ch, 11'h000};
    clearMon();
    applyStimulus(ch);
    checkOutput({tag, "_cmplt_clr"}, 32'(bus.cnv_cmplt), 32'd0);
    checkOutput({tag, "_ss_fall"}, 32'(bus.SS_n), 32'd0);
    if (busy_at > 0) begin
      repeat (busy_at - 1) tick();
      bus.chnnl = 3'd6;
      bus.start_conv = 1'b1;
      tick();
      bus.start_conv = 1'b0;
    end
    waitCmplt(prev, lat, changed);
    checkOutput({tag, "_latency"}, 32'(lat), 32'(LATENCY));
    checkOutput({tag, "_result"}, 32'(bus.A2D_res), 32'(data));
    checkOutput({tag, "_res_held"}, 32'(changed), 32'd0);
    checkOutput({tag, "_frames"}, 32'(low_len_q.size()), 32'd2);
    for (int f = 0; f < low_len_q.size(); f++) begin
      checkOutput({tag, "_ss_low"}, 32'(low_len_q[f]), 32'(FRAME_LOW));
      checkOutput({tag, "_sclk_rises"}, 32'(rises_q[f]), 32'd16);
      checkOutput({tag, "_mosi"}, 32'(mosi_q[f]), 32'(exp_cmd));
    end
    checkOutput({tag, "_gaps"}, 32'(gap_q.size()), 32'd1);
    if (gap_q.size() > 0) checkOutput({tag, "_gap_len"}, 32'(gap_q[0]), 32'(GAP_CLKS));
  endtask

  initial begin
    bus.start_conv = 1'b0;
    bus.chnnl = 3'd0;
    bus.MISO = 1'b0;
    foreach (adc_data[i]) adc_data[i] = 12'($urandom);

    repeat (3) tick();
    checkOutput("rst_ss_n", 32'(bus.SS_n), 32'd1);
    checkOutput("rst_sclk", 32'(bus.SCLK), 32'd1);
    checkOutput("rst_mosi", 32'(bus.MOSI), 32'd0);
    checkOutput("rst_cmplt", 32'(bus.cnv_cmplt), 32'd0);
    checkOutput("rst_res", 32'(bus.A2D_res), 32'd0);
    rst_n = 1'b1;
    repeat (5) tick();

    $display("[TB] basic conversion");
    runConversion(3'd3, 12'hABC, 0, "basic");

    $display("[TB] channel sweep");
    for (int ch = 0; ch < 8; ch++) begin
      repeat ($urandom_range(0, 20)) tick();
      runConversion(3'(ch), 12'(12'h100 * ch + 5), 0, "sweep");
    end

    $display("[TB] busy ignore");
    repeat (4) tick();
    runConversion(3'd2, 12'($urandom), 300, "busy");

    $display("[TB] back-to-back");
    runConversion(3'd4, 12'($urandom), 0, "b2b");

    $display("[TB] edge data");
    runConversion(3'($urandom), 12'hFFF, 0, "ones");
    runConversion(3'($urandom), 12'h000, 0, "zeros");

    $display("[TB] random conversions");
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 40)) tick();
      runConversion(3'($urandom), 12'($urandom), 0, "rand");
    end

    $display("[TB] reset mid-frame");
    runConversion(3'd5, 12'h5A5, 0, "pre_rst");
    repeat (3) tick();
    applyStimulus(3'd5);
    repeat (200) tick();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    checkOutput("midrst_ss_n", 32'(bus.SS_n), 32'd1);
    checkOutput("midrst_sclk", 32'(bus.SCLK), 32'd1);
    checkOutput("midrst_mosi", 32'(bus.MOSI), 32'd0);
    checkOutput("midrst_cmplt", 32'(bus.cnv_cmplt), 32'd0);
    checkOutput("midrst_res", 32'(bus.A2D_res), 32'd0);
    tick();
    clearMon();
    repeat (1200) tick();
    checkOutput("midrst_no_frame", 32'(low_len_q.size()), 32'd0);
    checkOutput("midrst_no_cmplt", 32'(bus.cnv_cmplt), 32'd0);
    checkOutput("midrst_ss_idle", 32'(bus.SS_n), 32'd1);

    runConversion(3'd7, 12'($urandom), 0, "recover");
    checkOutput("sclk_idle_edges", 32'(idle_edges), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
